// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous FIFO control stage.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 4;
  localparam int unsigned DEF_AFULL_MARGIN = 2;
  localparam int unsigned DEF_AEMPTY_TH    = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// One FIFO pointer with a wrap bit; advances on inc and exposes the RAM address bits.
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  assign addr = ptr[ADDR_WIDTH-1:0];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO control: pointers, RAM write enable/addresses, occupancy, flags, error pulses.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY = 0,
  parameter int unsigned AFULL_TH   = (2 ** ADDR_WIDTH) - DEF_AFULL_MARGIN,
  parameter int unsigned AEMPTY_TH  = DEF_AEMPTY_TH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;

  // Acceptance is judged against the registered flags only.
  assign push      = wr_en & ~full;
  assign pop       = rd_en & ~empty;
  assign ram_wr_en = push;
  assign rd_ack    = pop;

  fifo_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (push),
    .addr (ram_wr_addr)
  );

  fifo_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (pop),
    .addr (ram_rd_addr)
  );

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Flags derive from count_next so they line up with count one cycle after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      full         <= (count_next == CNT_W'(DEPTH));
      empty        <= (count_next == CNT_W'(0));
      almost_full  <= (count_next >= CNT_W'(AFULL_TH));
      almost_empty <= (count_next <= CNT_W'(AEMPTY_TH));
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

  if (RD_LATENCY == 0) begin : g_rd_comb
    assign rd_valid = rd_ack;
  end else begin : g_rd_reg
    // The RAM output register captures the pre-increment address, so valid trails ack by one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_ack;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed self-checking bench for fifo_sync_ctrl (DEPTH=16, AFULL_TH=14, AEMPTY_TH=2, registered read).
module tb_fifo_sync_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [3:0] ram_rd_addr;
  logic       rd_ack;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks;
  int n_fail;

  fifo_sync_ctrl #(
    .ADDR_WIDTH (4),
    .RD_LATENCY (1),
    .AFULL_TH   (14),
    .AEMPTY_TH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_addr  (ram_rd_addr),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc();
    n_checks++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_flags: got e/ae/f/af=%b want 1100", {empty, almost_empty, full, almost_full});
    end
    n_checks++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++;
    if (ram_wr_addr !== 4'd0 || ram_rd_addr !== 4'd0) begin
      n_fail++; $display("FAIL reset_addr: got wr=%0d rd=%0d want 0/0", ram_wr_addr, ram_rd_addr);
    end
    n_checks++;
    if ({overflow, underflow, rd_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got ovf/unf/rv=%b want 000", {overflow, underflow, rd_valid});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      n_checks++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'(i)) begin
        n_fail++; $display("FAIL fill_wr[%0d]: got en=%b addr=%0d want 1/%0d", i, ram_wr_en, ram_wr_addr, i);
      end
      cyc();
      n_checks++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16) || empty !== 1'b0) begin
        n_fail++; $display("FAIL fill_state[%0d]: got cnt=%0d af=%b f=%b e=%b want %0d/%b/%b/0",
                           i, count, almost_full, full, empty, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    n_checks++;
    if (ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL fill_17th_en: got %b want 0", ram_wr_en); end
    cyc();
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || ram_wr_addr !== 4'd0) begin
      n_fail++; $display("FAIL fill_overflow: got ovf=%b cnt=%0d wa=%0d want 1/16/0", overflow, count, ram_wr_addr);
    end
    wr_en = 1'b0;
    cyc();
    n_checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++; $display("FAIL fill_ovf_pulse: got ovf=%b f=%b want 0/1", overflow, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      #1;
      n_checks++;
      if (rd_ack !== 1'b1 || ram_rd_addr !== 4'(i) || rd_valid !== (i > 0)) begin
        n_fail++; $display("FAIL drain_rd[%0d]: got ack=%b addr=%0d rv=%b want 1/%0d/%b",
                           i, rd_ack, ram_rd_addr, rd_valid, i, (i > 0));
      end
      cyc();
      n_checks++;
      if (count !== 5'(15 - i) || empty !== (i == 15) || full !== 1'b0 || almost_empty !== (15 - i <= 2)) begin
        n_fail++; $display("FAIL drain_state[%0d]: got cnt=%0d e=%b f=%b ae=%b want %0d/%b/0/%b",
                           i, count, empty, full, almost_empty, 15 - i, (i == 15), (15 - i <= 2));
      end
    end
    n_checks++;
    if (rd_ack !== 1'b0 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_extra: got ack=%b rv=%b want 0/1", rd_ack, rd_valid);
    end
    cyc();
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || ram_rd_addr !== 4'd0 || count !== 5'd0) begin
      n_fail++; $display("FAIL drain_underflow: got unf=%b rv=%b ra=%0d cnt=%0d want 1/0/0/0",
                         underflow, rd_valid, ram_rd_addr, count);
    end
    rd_en = 1'b0;
    cyc();
    n_checks++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_unf_pulse: got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1;
    repeat (5) cyc();
    n_checks++;
    if (count !== 5'd5 || ram_wr_addr !== 4'd5 || ram_rd_addr !== 4'd0) begin
      n_fail++; $display("FAIL b2b_setup: got cnt=%0d wa=%0d ra=%0d want 5/5/0", count, ram_wr_addr, ram_rd_addr);
    end
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      n_checks++;
      if (ram_wr_addr !== 4'((5 + k) % 16) || ram_rd_addr !== 4'(k % 16) || ram_wr_en !== 1'b1 || rd_ack !== 1'b1) begin
        n_fail++; $display("FAIL b2b_addr[%0d]: got wa=%0d ra=%0d en=%b ack=%b want %0d/%0d/1/1",
                           k, ram_wr_addr, ram_rd_addr, ram_wr_en, rd_ack, (5 + k) % 16, k % 16);
      end
      cyc();
      n_checks++;
      if (count !== 5'd5 || {full, empty, almost_full, almost_empty} !== 4'b0000 || rd_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_state[%0d]: got cnt=%0d flags=%b rv=%b want 5/0000/1",
                           k, count, {full, empty, almost_full, almost_empty}, rd_valid);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    cyc();
  endtask

  task automatic test_corners();
    wr_en = 1'b1;
    repeat (11) cyc();
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL corner_fill: got f=%b cnt=%0d want 1/16", full, count);
    end
    rd_en = 1'b1;
    #1;
    n_checks++;
    if (ram_wr_en !== 1'b0 || rd_ack !== 1'b1) begin
      n_fail++; $display("FAIL corner_full_acc: got en=%b ack=%b want 0/1", ram_wr_en, rd_ack);
    end
    cyc();
    n_checks++;
    if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL corner_full: got cnt=%0d ovf=%b f=%b unf=%b want 15/1/0/0", count, overflow, full, underflow);
    end
    wr_en = 1'b0;
    repeat (15) cyc();
    n_checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++; $display("FAIL corner_drain: got e=%b cnt=%0d want 1/0", empty, count);
    end
    wr_en = 1'b1;
    #1;
    n_checks++;
    if (ram_wr_en !== 1'b1 || rd_ack !== 1'b0) begin
      n_fail++; $display("FAIL corner_empty_acc: got en=%b ack=%b want 1/0", ram_wr_en, rd_ack);
    end
    cyc();
    n_checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || empty !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL corner_empty: got cnt=%0d unf=%b e=%b ovf=%b want 1/1/0/0", count, underflow, empty, overflow);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1;
    repeat (8) cyc();
    wr_en = 1'b0;
    n_checks++;
    if (count !== 5'd9) begin n_fail++; $display("FAIL areset_setup: got cnt=%0d want 9", count); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (count !== 5'd0 || {empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_fail++; $display("FAIL areset_state: got cnt=%0d e/ae/f/af=%b want 0/1100", count, {empty, almost_empty, full, almost_full});
    end
    n_checks++;
    if (ram_wr_addr !== 4'd0 || ram_rd_addr !== 4'd0 || {overflow, underflow, rd_valid} !== 3'b000) begin
      n_fail++; $display("FAIL areset_ptr: got wa=%0d ra=%0d pulses=%b want 0/0/000", ram_wr_addr, ram_rd_addr,
                         {overflow, underflow, rd_valid});
    end
    cyc();
    rst = 1'b0;
    cyc();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL areset_release: got cnt=%0d e=%b want 0/1", count, empty);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_corners();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
